muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit. It sits directly downstream of the register file: it consumes the two read-port operands and the destination index, and produces a result/rd pair for the register-file write port. The core stalls on `busy` and commits the write on `done`. A shift-add multiplier and a restoring divider share one 64-bit accumulator and one 32-cycle iteration counter.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_step.sv | 33 +++
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared RV32M multiply/divide definitions: funct3 encodings, FSM states, widths.
// Also used by the decoder that drives start/funct3 into muldiv_unit.
package muldiv_pkg;

    localparam int XLEN = 32;
    localparam int ITER = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration on the {hi, lo} accumulator: shift-add for multiply,
// restoring trial-subtract for divide. Zero latency, no flow control.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shl_hi;
    logic [XLEN:0] trial;

    always_comb begin
        sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        shl_hi = acc_i[2*XLEN-1:XLEN-1];
        trial  = shl_hi - {1'b0, opnd_i};
        acc_o  = acc_i;
        if (div_i) begin
            // Borrow out of bit XLEN means the shifted remainder was smaller than the divisor.
            if (!trial[XLEN]) begin
                acc_o = {trial[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = {shl_hi[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div: 34-cycle start-to-done, 1 cycle for div-by-zero/overflow.
// Core stalls on busy; start is only sampled in IDLE/DONE and never queued.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("muldiv_unit supports XLEN=32 only");
    end
    if ((2 ** CNT_W) <= XLEN) begin : g_bad_cnt
        $error("muldiv_unit CNT_W too narrow for XLEN iterations");
    end

    logic [1:0]        state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [2*XLEN-1:0] acc_q,     acc_d;
    logic [XLEN-1:0]   opb_q,     opb_d;
    logic [2:0]        f3_q,      f3_d;
    logic              neg_a_q,   neg_a_d;
    logic              neg_b_q,   neg_b_d;
    logic [4:0]        rd_lat_q,  rd_lat_d;
    logic [4:0]        rd_out_q,  rd_out_d;
    logic [XLEN-1:0]   result_q,  result_d;

    logic              accept;
    logic              sgn_a_op, sgn_b_op, neg_a, neg_b;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   spec_res;
    logic [2*XLEN-1:0] step_acc;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem, fix_res;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .div_i  (f3_q[2]),
        .acc_i  (acc_q),
        .opnd_i (opb_q),
        .acc_o  (step_acc)
    );

    always_comb begin
        accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        sgn_a_op = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV)  || (funct3 == F3_REM);
        sgn_b_op = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        neg_a    = sgn_a_op && op_a[XLEN-1];
        neg_b    = sgn_b_op && op_b[XLEN-1];
        abs_a    = neg_a ? -op_a : op_a;
        abs_b    = neg_b ? -op_b : op_b;
        div_zero = funct3[2] && (op_b == '0);
        div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                   (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        if (div_zero) begin
            spec_res = funct3[1] ? op_a : '1;
        end else begin
            spec_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // Sign correction on the unsigned magnitudes left in the accumulator.
    always_comb begin
        prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quot = acc_q[XLEN-1:0];
        rem  = acc_q[2*XLEN-1:XLEN];
        if (!f3_q[2]) begin
            fix_res = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else if (f3_q[1]) begin
            fix_res = neg_a_q ? -rem : rem;
        end else begin
            fix_res = (neg_a_q ^ neg_b_q) ? -quot : quot;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        f3_d     = f3_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        rd_lat_d = rd_lat_q;
        rd_out_d = rd_out_q;
        result_d = result_q;
        case (state_q)
            S_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                result_d = fix_res;
                rd_out_d = rd_lat_q;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            f3_d     = funct3;
            rd_lat_d = rd_in;
            neg_a_d  = neg_a;
            neg_b_d  = neg_b;
            opb_d    = abs_b;
            acc_d    = {{XLEN{1'b0}}, abs_a};
            cnt_d    = '0;
            if (div_zero || div_ovf) begin
                result_d = spec_res;
                rd_out_d = rd_in;
                state_d  = S_DONE;
            end else begin
                state_d  = S_CALC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            f3_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            rd_lat_q <= '0;
            rd_out_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            f3_q     <= f3_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            rd_lat_q <= rd_lat_d;
            rd_out_q <= rd_out_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_CALC) || (state_q == S_FIXUP);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, busy/reset sequences, random ops vs. arithmetic model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_chk  = 0;
    int n_pass = 0;

    muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    // Reference built from the RV32M definitions using 64-bit integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa;
        int sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'b001: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            3'b010: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Counts clock edges from the accepting edge to the edge that raises done (-1 on timeout).
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (busy) bcnt++;
            if (lat >= 100) begin
                lat = -1;
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                         output int lat, output int bcnt);
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
        wait_done(lat, bcnt);
        res = result;
        rdo = rd_out;
    endtask

    initial begin
        logic [31:0] res;
        logic [4:0]  rdo;
        int lat;
        int bcnt;
        int seen;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;

        tbl[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34};
        tbl[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 34};
        tbl[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 34};
        tbl[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 34};
        tbl[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFD, 34};
        tbl[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 34};
        tbl[6]  = '{3'b101, 32'h8000_0000, 32'h0000_0003, 5'd7,  32'h2AAA_AAAA, 34};
        tbl[7]  = '{3'b111, 32'h8000_0000, 32'h0000_0003, 5'd8,  32'h0000_0002, 34};
        tbl[8]  = '{3'b100, 32'h0000_0005, 32'h0000_0000, 5'd10, 32'hFFFF_FFFF, 1};
        tbl[9]  = '{3'b111, 32'h0000_0005, 32'h0000_0000, 5'd11, 32'h0000_0005, 1};
        tbl[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1};
        tbl[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 1};
        tbl[12] = '{3'b000, 32'h0000_0000, 32'h0001_2345, 5'd14, 32'h0000_0000, 34};

        rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd_out", 32'(rd_out), 32'd0);

        for (int i = 0; i < 13; i++) begin
            do_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rd, res, rdo, lat, bcnt);
            check($sformatf("tbl%0d_result", i), res, tbl[i].exp);
            check($sformatf("tbl%0d_rd", i), 32'(rdo), 32'(tbl[i].rd));
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
            check($sformatf("tbl%0d_busy_cycles", i), 32'(bcnt), (tbl[i].lat == 34) ? 32'd33 : 32'd0);
        end

        // Second start during CALC is dropped; a start in the DONE cycle is taken immediately.
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5; rd_in = 5'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        forever begin
            @(negedge clk);
            start = (lat == 10);
            if (lat == 10) begin
                funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd2;
            end
            if (done || lat >= 100) break;
            @(posedge clk);
            lat++;
        end
        check("busy_start_latency", 32'(lat), 32'd34);
        check("busy_start_result", result, 32'd15);
        check("busy_start_rd", 32'(rd_out), 32'd1);
        funct3 = 3'b000; op_a = 32'd6; op_b = 32'd7; rd_in = 5'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bcnt);
        check("b2b_latency", 32'(lat), 32'd34);
        check("b2b_result", result, 32'd42);
        check("b2b_rd", 32'(rd_out), 32'd3);
        repeat (3) @(negedge clk);
        check("result_held", result, 32'd42);

        // Reset while CALC counter is at 15.
        @(negedge clk);
        funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_rd_out", 32'(rd_out), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("midrst_no_done", 32'(seen), 32'd0);
        do_op(3'b101, 32'd1000, 32'd3, 5'd9, res, rdo, lat, bcnt);
        check("post_rst_result", res, 32'd333);
        check("post_rst_rd", 32'(rdo), 32'd9);
        check("post_rst_latency", 32'(lat), 32'd34);

        for (int i = 0; i < 300; i++) begin
            f  = 3'($urandom);
            a  = pick();
            b  = pick();
            rd = 5'($urandom);
            do_op(f, a, b, rd, res, rdo, lat, bcnt);
            check($sformatf("rnd%0d_f%0d_%08h_%08h_result", i, f, a, b), res, ref_model(f, a, b));
            check($sformatf("rnd%0d_rd", i), 32'(rdo), 32'(rd));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(ref_latency(f, a, b)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
